// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and output rounding for the 64-tap FIR engine.
package fir_pkg;

    localparam int NTAPS = 64;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int FRAC  = 15;
    localparam int AW    = $clog2(NTAPS);
    localparam int ACC_W = DW + CW + AW;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 <<< (DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SMIN = -ACC_W'(1 <<< (DW - 1));

    function automatic logic signed [DW-1:0] round_sat(
        input logic signed [ACC_W-1:0] a,
        input int                      frac
    );
        logic signed [ACC_W-1:0] half;
        logic signed [ACC_W-1:0] r;
        half = '0;
        half[frac-1] = 1'b1;
        r = a + half;
        r = r >>> frac;
        if (r > SMAX) begin
            r = SMAX;
        end else if (r < SMIN) begin
            r = SMIN;
        end
        return r[DW-1:0];
    endfunction

endpackage

// File: rtl/fir_mac64_dline.sv
// Circular sample history; read port addresses by age k (0 = newest sample).
module fir_mac64_dline #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [W-1:0]         wdata,
    input  logic [$clog2(N)-1:0] k,
    output logic [W-1:0]         rdata
);

    localparam int AW = $clog2(N);

    logic [W-1:0]  mem [N];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // wr_ptr already points past the newest slot, hence the extra -1.
    assign rd_ptr = wr_ptr - AW'(1) - k;
    assign rdata  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
        end
    end

endmodule

// File: rtl/fir_mac64.sv
// Time-multiplexed FIR: one accepted sample, NTAPS MAC cycles, one rounded output.
module fir_mac64 #(
    parameter int NTAPS = 64,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int FRAC  = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    output logic [$clog2(NTAPS)-1:0] cmem_a,
    input  logic [CW-1:0]            cmem_q,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data
);

    import fir_pkg::*;

    localparam int KW = $clog2(NTAPS);
    localparam logic [KW-1:0] KLAST = KW'(NTAPS - 1);

    state_t                   state;
    state_t                   state_nx;
    logic                     live;
    logic                     accept;
    logic [KW-1:0]            k;
    logic [DW-1:0]            sample;
    logic signed [DW+CW-1:0]  prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;

    fir_mac64_dline #(
        .N (NTAPS),
        .W (DW)
    ) u_dline (
        .clk   (clk),
        .rst   (rst),
        .we    (accept),
        .wdata (in_data),
        .k     (k),
        .rdata (sample)
    );

    assign accept  = in_valid & in_ready;
    assign prod    = $signed(cmem_q) * $signed(sample);
    assign acc_sum = acc + ACC_W'(prod);

    // live keeps in_ready low while rst is held, even though state is IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            live  <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        cmem_a    = '0;
        unique case (state)
            IDLE: begin
                in_ready = live;
                if (in_valid && live) begin
                    state_nx = MAC;
                end
            end
            MAC: begin
                cmem_a = k;
                if (k == KLAST) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
        end else if (accept) begin
            k   <= '0;
            acc <= '0;
        end else if (state == MAC) begin
            acc <= acc_sum;
            k   <= k + KW'(1);
            if (k == KLAST) begin
                out_data <= round_sat(acc_sum, FRAC);
            end
        end
    end

endmodule

// File: tb/tb_fir_mac64.sv
// Directed bench for fir_mac64 with a behavioural coefficient ROM and reference model.
module tb_fir_mac64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [5:0]  cmem_a;
    logic [15:0] cmem_q;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;

    int n_assert = 0;
    int n_fail   = 0;
    int hist[$];

    fir_mac64 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cmem_a    (cmem_a),
        .cmem_q    (cmem_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Symmetric ROM: c0=c63=-1, c3=c60=3, c31=c32=0x2500, else j^3-8j.
    function automatic logic signed [15:0] coef(input int k);
        int j;
        j = (k < 32) ? k : 63 - k;
        if (j == 0) return -16'sd1;
        if (j == 31) return 16'sh2500;
        return 16'(j * j * j - 8 * j);
    endfunction

    always_comb cmem_q = coef(int'(cmem_a));

    function automatic logic [15:0] model_out();
        longint acc;
        longint r;
        int n;
        acc = 0;
        n = hist.size() - 1;
        for (int k = 0; k < 64; k++) begin
            if (n - k >= 0) begin
                acc += longint'(coef(k)) * longint'(hist[n-k]);
            end
        end
        r = (acc + 16384) >>> 15;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return 16'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, output logic [15:0] y);
        int g;
        g = 0;
        while (!in_ready && g < 200) begin
            step();
            g++;
        end
        if (g >= 200) chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b1;
        in_data  = x;
        hist.push_back(int'($signed(x)));
        step();
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 200) begin
            step();
            g++;
        end
        if (g >= 200) chk("out_valid_timeout", 32'd0, 32'd1);
        y = out_data;
        step();
    endtask

    initial begin
        logic [15:0] y;
        logic [15:0] outs[64];
        logic [15:0] held;
        logic [15:0] ex;
        int bad;
        int cnt;

        // Reset state
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_cmem_a", 32'(cmem_a), 32'd0);
        rst = 1'b0;
        chk("rel_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Impulse sample 0: latency, address sweep and backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h7FFF;
        hist.push_back(32767);
        step();
        in_valid = 1'b0;
        bad = 0;
        for (int i = 1; i <= 64; i++) begin
            if (in_ready !== 1'b0) bad++;
            if (out_valid !== 1'b0) bad++;
            if (cmem_a !== 6'(i - 1)) bad++;
            step();
        end
        chk("mac_window_bad", 32'(bad), 32'd0);
        chk("lat_out_valid", 32'(out_valid), 32'd1);
        chk("lat_in_ready", 32'(in_ready), 32'd0);
        held = out_data;
        outs[0] = out_data;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1) bad++;
            if (in_ready !== 1'b0) bad++;
            if (out_data !== held) bad++;
            step();
        end
        chk("bp_hold_bad", 32'(bad), 32'd0);
        out_ready = 1'b1;
        chk("bp_still_valid", 32'(out_valid), 32'd1);
        step();
        chk("bp_done_valid", 32'(out_valid), 32'd0);
        chk("bp_done_ready", 32'(in_ready), 32'd1);

        // Impulse sample 1: throughput timing
        in_valid = 1'b1;
        in_data  = 16'h0000;
        hist.push_back(0);
        step();
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 200) begin
            step();
            cnt++;
        end
        chk("tp_latency", 32'(cnt), 32'd65);
        outs[1] = out_data;
        step();
        chk("tp_ready_66", 32'(in_ready), 32'd1);

        for (int i = 2; i < 64; i++) begin
            send(16'h0000, y);
            outs[i] = y;
        end
        chk("imp_out0", 32'(outs[0]), 32'hFFFF);
        chk("imp_out3", 32'(outs[3]), 32'h0003);
        chk("imp_out31", 32'(outs[31]), 32'h2500);
        chk("imp_out32", 32'(outs[32]), 32'h2500);
        chk("imp_out63", 32'(outs[63]), 32'hFFFF);
        bad = 0;
        for (int j = 0; j < 64; j++) begin
            longint r;
            r = (32767 * longint'(coef(j)) + 16384) >>> 15;
            if (outs[j] !== 16'(r)) bad++;
        end
        chk("imp_all_bad", 32'(bad), 32'd0);

        // Saturation low then high
        for (int i = 0; i < 64; i++) begin
            send((coef(63 - i) > 0) ? 16'h8000 : 16'h7FFF, y);
        end
        chk("sat_neg", 32'(y), 32'h8000);
        for (int i = 0; i < 64; i++) begin
            send((coef(63 - i) > 0) ? 16'h7FFF : 16'h8000, y);
        end
        chk("sat_pos", 32'(y), 32'h7FFF);

        // Random stream across wr_ptr wraps
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            send(16'($urandom), y);
            ex = model_out();
            if (y !== ex) begin
                bad++;
                $display("FAIL rand_out[%0d] observed=%h expected=%h", i, y, ex);
            end
        end
        n_assert++;
        assert (bad == 0) else begin
            n_fail++;
            $error("FAIL rand_stream observed=%0d expected=0", bad);
        end

        // Reset while k==20
        in_valid = 1'b1;
        in_data  = 16'h4000;
        step();
        in_valid = 1'b0;
        cnt = 0;
        while (cmem_a != 6'd20 && cnt < 200) begin
            step();
            cnt++;
        end
        chk("mid_k20", 32'(cmem_a), 32'd20);
        rst = 1'b1;
        #1;
        chk("mid_rst_cmem_a", 32'(cmem_a), 32'd0);
        step();
        step();
        rst = 1'b0;
        hist.delete();
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid !== 1'b0) bad++;
            step();
        end
        chk("mid_no_valid", 32'(bad), 32'd0);
        send(16'h7FFF, y);
        chk("post_rst_out0", 32'(y), 32'hFFFF);
        send(16'h0000, y);
        chk("post_rst_out1", 32'(y), 32'hFFF9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
